shift_seq: RTL
==============

SHIFT_SEQ -- requirements
Module: shift_seq

Interface
REQ-001 Parameter WIDTH, default 1: bits per sample on i_data, i_sr_par lanes, o_sr_data.
REQ-002 Parameter LENGTH, default 8: samples per frame; legal range 2..255.
REQ-003 Port i_clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port i_rst  input  1  reset, synchronous and active-high.
REQ-005 Port i_en  input  1  global clock enable; when low, all registers hold.
REQ-006 Port i_arm  input  1  level; high = run continuous frame capture, low = stop.
REQ-007 Port i_sample  input  1  one-cycle strobe: i_data holds a new sample.
REQ-008 Port i_data  input  WIDTH  sample from the modulator bitstream.
REQ-009 Port i_sr_par  input  LENGTH*WIDTH  parallel output of the external shift register.
REQ-010 Port i_ready  input  1  downstream accepts o_frame this cycle.
REQ-011 Port o_sr_en  output  1  enable to the shift register (combinational).
REQ-012 Port o_sr_rst  output  1  reset to the shift register (combinational).
REQ-013 Port o_sr_data  output  WIDTH  data to the shift register, equal to i_data.
REQ-014 Port o_frame  output  LENGTH*WIDTH  captured frame; bits [WIDTH-1:0] = newest sample.
REQ-015 Port o_valid  output  1  o_frame holds an unconsumed frame.
REQ-016 Port o_busy  output  1  high in any state except IDLE.
REQ-017 Port o_ovf  output  1  sticky: at least one completed frame was dropped.
REQ-018 Port o_drop_cnt  output  8  saturating count of dropped frames.

Function
REQ-019 States SHALL be IDLE, CLEAR, FILL, CAPTURE, encoded in a 2-bit register.
REQ-020 A sample SHALL be accepted when i_en & i_sample & state in {FILL, CAPTURE}; o_sr_en = acceptance, o_sr_rst = 0 in that cycle.
REQ-021 In CLEAR, or while i_rst high, o_sr_en = 1 and o_sr_rst = 1; otherwise o_sr_rst = 0.
REQ-022 IDLE -> CLEAR when i_en & i_arm; CLEAR -> FILL after exactly one enabled cycle, sample count cnt = 0.
REQ-023 In FILL, each accepted sample increments cnt (width ceil(log2(LENGTH))+1); accepted sample with cnt = LENGTH-1 -> CAPTURE, cnt = 0.
REQ-024 CAPTURE SHALL last one enabled cycle, sample i_sr_par (already holding all LENGTH samples), then -> FILL; a sample accepted during CAPTURE sets cnt = 1.
REQ-025 Capture load: if o_valid = 0, or o_valid & i_ready in the same cycle, o_frame <= i_sr_par and o_valid <= 1.
REQ-026 Capture drop: if o_valid & !i_ready, o_frame unchanged, o_ovf <= 1, o_drop_cnt increments, saturating at 255.
REQ-027 Handshake: o_valid & i_ready with no capture that cycle -> o_valid <= 0; o_frame SHALL not change while o_valid = 1 unless a handshake completes that cycle.
REQ-028 i_arm low in CLEAR or FILL (i_en high) -> IDLE next cycle; partial frame discarded; a pending o_valid frame retained.
REQ-029 i_arm low in CAPTURE: capture completes per REQ-025/026, then -> IDLE.
REQ-030 i_sample in IDLE or CLEAR SHALL be ignored (o_sr_en stays as REQ-021).
REQ-031 i_en low: state, cnt, o_frame, o_valid, o_ovf, o_drop_cnt hold; o_sr_en = 0 (except during i_rst); i_ready ignored.
REQ-032 o_ovf and o_drop_cnt SHALL be cleared only by i_rst.

Reset
REQ-033 i_rst high SHALL, independent of i_en, force state IDLE, cnt 0, o_frame 0, o_valid 0, o_ovf 0, o_drop_cnt 0, o_busy 0.
REQ-034 i_rst mid-frame or with o_valid = 1 SHALL discard all data; arm must be reasserted after release.

Verification (LENGTH=4, WIDTH=1)
REQ-035 Arm, samples 1,0,1,1 on consecutive strobes, i_ready=1 -> CLEAR one cycle, o_frame = 4'b1011, o_valid one cycle after CAPTURE entry.
REQ-036 i_ready=0, two full frames -> first frame held, o_ovf=1, o_drop_cnt=1; then i_ready=1 -> o_valid drops next cycle.
REQ-037 Sample strobe during CAPTURE cycle -> accepted, next frame completes after 3 further samples.
REQ-038 i_arm deasserted after 2 samples -> IDLE, o_busy=0, no o_valid; re-arm -> CLEAR then fresh 4-sample frame.
REQ-039 i_en low for 5 cycles mid-FILL with strobes -> no o_sr_en, cnt unchanged; resumes correctly.
REQ-040 300 drops with i_ready=0 -> o_drop_cnt saturates at 255; i_rst -> all outputs 0.

Source files
------------

// File: rtl/shift_seq.sv
// shift_seq: sequences an external shift register into frames of LENGTH samples with a valid/ready output
module shift_seq #(
   parameter int WIDTH  = 1,
   parameter int LENGTH = 8
) (
   input  logic                      i_clk,
   input  logic                      i_rst,
   input  logic                      i_en,
   input  logic                      i_arm,
   input  logic                      i_sample,
   input  logic [WIDTH-1:0]          i_data,
   input  logic [LENGTH*WIDTH-1:0]   i_sr_par,
   input  logic                      i_ready,
   output logic                      o_sr_en,
   output logic                      o_sr_rst,
   output logic [WIDTH-1:0]          o_sr_data,
   output logic [LENGTH*WIDTH-1:0]   o_frame,
   output logic                      o_valid,
   output logic                      o_busy,
   output logic                      o_ovf,
   output logic [7:0]                o_drop_cnt
);
   localparam int CW = $clog2(LENGTH) + 1;

   typedef enum logic [1:0] {IDLE, CLEAR, FILL, CAPTURE} state_t;

   state_t                    r_state, w_state_nxt;
   logic [CW-1:0]             r_cnt, w_cnt_nxt;
   logic [LENGTH*WIDTH-1:0]   r_frame;
   logic                      r_valid;
   logic                      r_ovf;
   logic [7:0]                r_drop_cnt;
   logic                      w_accept;
   logic                      w_capture;
   logic                      w_clear;

   assign w_accept   = i_en & i_sample & (r_state == FILL || r_state == CAPTURE);
   assign w_capture  = i_en & (r_state == CAPTURE);
   assign w_clear    = r_state == CLEAR;
   assign o_sr_en    = i_rst | (i_en & w_clear) | w_accept;
   assign o_sr_rst   = i_rst | w_clear;
   assign o_sr_data  = i_data;
   assign o_frame    = r_frame;
   assign o_valid    = r_valid;
   assign o_busy     = r_state != IDLE;
   assign o_ovf      = r_ovf;
   assign o_drop_cnt = r_drop_cnt;

   // next state and sample count; everything holds while i_en is low
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      if (i_en) begin
         case (r_state)
            IDLE: begin
               w_state_nxt = i_arm ? CLEAR : IDLE;
               w_cnt_nxt   = '0;
            end
            CLEAR: begin
               w_state_nxt = i_arm ? FILL : IDLE;
               w_cnt_nxt   = '0;
            end
            FILL: begin
               if (!i_arm) begin
                  w_state_nxt = IDLE;
                  w_cnt_nxt   = '0;
               end else if (w_accept) begin
                  w_state_nxt = (r_cnt == CW'(LENGTH - 1)) ? CAPTURE : FILL;
                  w_cnt_nxt   = (r_cnt == CW'(LENGTH - 1)) ? '0 : r_cnt + CW'(1);
               end
            end
            default: begin
               w_state_nxt = i_arm ? FILL : IDLE;
               w_cnt_nxt   = (i_arm & w_accept) ? CW'(1) : '0;
            end
         endcase
      end
   end

   // state and count registers
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // frame output: load on capture if the slot is free or being consumed, otherwise count a drop
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_frame    <= '0;
         r_valid    <= 1'b0;
         r_ovf      <= 1'b0;
         r_drop_cnt <= '0;
      end else if (w_capture) begin
         if (!r_valid || i_ready) begin
            r_frame <= i_sr_par;
            r_valid <= 1'b1;
         end else begin
            r_ovf      <= 1'b1;
            r_drop_cnt <= (r_drop_cnt == 8'hFF) ? r_drop_cnt : r_drop_cnt + 8'd1;
         end
      end else if (i_en && r_valid && i_ready) begin
         r_valid <= 1'b0;
      end
   end
endmodule
